seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter LEN, default 3, giving the pattern length in bits (legal range 2..8).
REQ-002 The block SHALL have parameter CW, default 8, giving the width of each match counter.
REQ-003 The block SHALL have parameter PA_RST, default 3'b001 (LEN bits), giving the reset value of pattern A.
REQ-004 The block SHALL have parameter PB_RST, default 3'b110 (LEN bits), giving the reset value of pattern B.
REQ-005 The block SHALL have port ck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rs, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port en, input, 1 bit: the serial bit is valid this cycle.
REQ-008 The block SHALL have port i, input, 1 bit: the serial data bit.
REQ-009 The block SHALL have port ovl, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-010 The block SHALL have port cfg_we, input, 1 bit: load new patterns.
REQ-011 The block SHALL have ports cfg_a and cfg_b, input, LEN bits each: new patterns A and B, MSB = oldest bit.
REQ-012 The block SHALL have port clr, input, 1 bit: synchronous clear of both counters.
REQ-013 The block SHALL have ports y1 and y2, output, 1 bit each: registered match pulses for A and B.
REQ-014 The block SHALL have ports cnt1 and cnt2, output, CW bits each: match counts for A and B.
REQ-015 The block SHALL have port fill, output, clog2(LEN+1) bits: number of valid history bits, 0..LEN.

Function
REQ-016 On each edge with en=1 and cfg_we=0, i SHALL shift into the LEN-bit history (newest at LSB), and fill SHALL increment, saturating at LEN.
REQ-017 On edges with en=0, history and fill SHALL hold, and y1/y2 SHALL be 0.
REQ-018 Pattern A SHALL match when the post-shift fill equals LEN and the post-shift history equals pattern A; pattern B likewise.
REQ-019 y1 (y2) SHALL be 1 for exactly the cycle following the edge that shifted in the completing bit, otherwise 0 (latency: one edge from sampling).
REQ-020 When A and B match on the same edge, y1 and y2 SHALL both assert and both counters SHALL increment.
REQ-021 With ovl=1, fill SHALL remain LEN after a match, so overlapping occurrences are detected.
REQ-022 With ovl=0, any match SHALL set fill to 0, so the next match requires LEN fresh bits.
REQ-023 ovl SHALL be sampled on the same edge as the bit it applies to.
REQ-024 On an edge with cfg_we=1, cfg_a and cfg_b SHALL load, fill SHALL clear to 0, and any en/i on that edge SHALL be discarded (no shift, no match).
REQ-025 cnt1 (cnt2) SHALL increment by one on each A (B) match and saturate at 2^CW-1.
REQ-026 With clr=1, both counters SHALL become 0 on that edge; clr SHALL take priority over a simultaneous match increment.
REQ-027 clr SHALL NOT affect the history, fill, patterns or y outputs.

Reset
REQ-028 While rs=0, regardless of ck: history=0, fill=0, y1=y2=0, cnt1=cnt2=0, pattern A=PA_RST, pattern B=PB_RST.
REQ-029 Reset asserted mid-stream SHALL discard all partial history; no match SHALL be reported from bits received before reset.
REQ-030 Reset release SHALL be synchronous to ck, taking effect from the first rising edge after rs returns high.

Verification
REQ-031 Defaults, ovl=1, en=1, bits 0,0,1 -> y1=1 for one cycle after the third edge; cnt1=1; y2=0; fill=3.
REQ-032 ovl=1, bits 1,1,0,0,1 -> y2 after bit 3 and y1 after bit 5; then repeat with ovl=0 -> y2 after bit 3 and no y1; fill=2 at the end.
REQ-033 cfg_we with cfg_a=cfg_b=3'b101, then bits 1,0,1 -> y1 and y2 in the same cycle; cnt1=cnt2=1.
REQ-034 CW=2, ovl=1, bit stream 0,0,1 repeated five times -> cnt1 reaches 3 and stays 3; then clr coinciding with a match -> cnt1=0.
REQ-035 Bits 0,0 with en=1, then three cycles of en=0 (i toggling), then 1 with en=1 -> no shift during the gap; y1 after the final bit.
REQ-036 After bits 0,0, pulse rs low asynchronously mid-cycle, then send bit 1 -> all outputs 0 immediately during reset; no y1 after the 1; fill=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// Dual-pattern serial sequence detector with configurable overlap mode,
// runtime-loadable patterns and saturating match counters.
module seq_detect_param #(
   parameter int             LEN    = 3,
   parameter int             CW     = 8,
   parameter logic [LEN-1:0] PA_RST = LEN'(3'b001),
   parameter logic [LEN-1:0] PB_RST = LEN'(3'b110)
) (
   input  logic                         ck,
   input  logic                         rs,
   input  logic                         en,
   input  logic                         i,
   input  logic                         ovl,
   input  logic                         cfg_we,
   input  logic [LEN-1:0]               cfg_a,
   input  logic [LEN-1:0]               cfg_b,
   input  logic                         clr,
   output logic                         y1,
   output logic                         y2,
   output logic [CW-1:0]                cnt1,
   output logic [CW-1:0]                cnt2,
   output logic [$clog2(LEN+1)-1:0]     fill
);

   localparam int FW = $clog2(LEN+1);

   logic [LEN-1:0] hist_q, hist_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic [LEN-1:0] pa_q, pa_d;
   logic [LEN-1:0] pb_q, pb_d;
   logic           y1_q, y1_d;
   logic           y2_q, y2_d;
   logic [CW-1:0]  cnt1_q, cnt1_d;
   logic [CW-1:0]  cnt2_q, cnt2_d;

   logic [LEN-1:0] shifted;
   logic [FW-1:0]  fill_inc;
   logic           match_a;
   logic           match_b;

   always_comb begin
      hist_d   = hist_q;
      fill_d   = fill_q;
      pa_d     = pa_q;
      pb_d     = pb_q;
      y1_d     = 1'b0;
      y2_d     = 1'b0;
      cnt1_d   = cnt1_q;
      cnt2_d   = cnt2_q;
      shifted  = hist_q;
      fill_inc = fill_q;
      match_a  = 1'b0;
      match_b  = 1'b0;

      // A pattern load wins over the serial input on the same edge.
      if (cfg_we) begin
         pa_d   = cfg_a;
         pb_d   = cfg_b;
         fill_d = '0;
      end else if (en) begin
         shifted  = {hist_q[LEN-2:0], i};
         fill_inc = (fill_q == FW'(LEN)) ? fill_q : fill_q + 1'b1;
         match_a  = (fill_inc == FW'(LEN)) && (shifted == pa_q);
         match_b  = (fill_inc == FW'(LEN)) && (shifted == pb_q);
         hist_d   = shifted;
         fill_d   = (!ovl && (match_a || match_b)) ? '0 : fill_inc;
         y1_d     = match_a;
         y2_d     = match_b;
      end

      if (clr) begin
         cnt1_d = '0;
         cnt2_d = '0;
      end else begin
         if (match_a && (cnt1_q != {CW{1'b1}})) cnt1_d = cnt1_q + 1'b1;
         if (match_b && (cnt2_q != {CW{1'b1}})) cnt2_d = cnt2_q + 1'b1;
      end
   end

   always_ff @(posedge ck or negedge rs) begin
      if (!rs) begin
         hist_q <= '0;
         fill_q <= '0;
         pa_q   <= PA_RST;
         pb_q   <= PB_RST;
         y1_q   <= 1'b0;
         y2_q   <= 1'b0;
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pa_q   <= pa_d;
         pb_q   <= pb_d;
         y1_q   <= y1_d;
         y2_q   <= y2_d;
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   assign y1   = y1_q;
   assign y2   = y2_q;
   assign cnt1 = cnt1_q;
   assign cnt2 = cnt2_q;
   assign fill = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_seq_detect_param;

   localparam int LEN = 3;

   logic       ck = 1'b0;
   logic       rs = 1'b0;
   logic       en = 1'b0;
   logic       i = 1'b0;
   logic       ovl = 1'b0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_a = '0;
   logic [2:0] cfg_b = '0;
   logic       clr = 1'b0;

   logic       y1, y2, y1s, y2s;
   logic [7:0] cnt1, cnt2;
   logic [1:0] cnt1s, cnt2s;
   logic [1:0] fill, fills;

   int total = 0;
   int bad = 0;

   seq_detect_param dut (
      .ck(ck), .rs(rs), .en(en), .i(i), .ovl(ovl), .cfg_we(cfg_we),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .clr(clr),
      .y1(y1), .y2(y2), .cnt1(cnt1), .cnt2(cnt2), .fill(fill)
   );

   seq_detect_param #(.CW(2)) dut2 (
      .ck(ck), .rs(rs), .en(en), .i(i), .ovl(ovl), .cfg_we(cfg_we),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .clr(clr),
      .y1(y1s), .y2(y2s), .cnt1(cnt1s), .cnt2(cnt2s), .fill(fills)
   );

   always #5 ck = ~ck;

   // Reference model: the bits received since the last restart point.
   bit mq[$];
   int m_pa, m_pb, m_c1, m_c2, m_s1, m_s2;
   bit m_y1, m_y2;

   function automatic int pack_bits();
      int v = 0;
      foreach (mq[k]) v = v * 2 + int'(mq[k]);
      return v;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pa = 1; m_pb = 6;
      m_c1 = 0; m_c2 = 0; m_s1 = 0; m_s2 = 0;
      m_y1 = 0; m_y2 = 0;
   endtask

   task automatic model_edge(input bit e, input bit b, input bit o, input bit w,
                             input int a, input int bb, input bit c);
      bit ma = 0, mb = 0;
      if (w) begin
         m_pa = a; m_pb = bb;
         mq.delete();
      end else if (e) begin
         mq.push_back(b);
         if (mq.size() > LEN) void'(mq.pop_front());
         ma = (mq.size() == LEN) && (pack_bits() == m_pa);
         mb = (mq.size() == LEN) && (pack_bits() == m_pb);
         if (!o && (ma || mb)) mq.delete();
      end
      m_y1 = ma; m_y2 = mb;
      if (c) begin
         m_c1 = 0; m_c2 = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         m_c1 = sat(m_c1 + int'(ma), 255); m_c2 = sat(m_c2 + int'(mb), 255);
         m_s1 = sat(m_s1 + int'(ma), 3);   m_s2 = sat(m_s2 + int'(mb), 3);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".y1"}, int'(y1), int'(m_y1));
      chk({tag, ".y2"}, int'(y2), int'(m_y2));
      chk({tag, ".cnt1"}, int'(cnt1), m_c1);
      chk({tag, ".cnt2"}, int'(cnt2), m_c2);
      chk({tag, ".fill"}, int'(fill), mq.size());
      chk({tag, ".cnt1_cw2"}, int'(cnt1s), m_s1);
      chk({tag, ".cnt2_cw2"}, int'(cnt2s), m_s2);
      chk({tag, ".fill_cw2"}, int'(fills), mq.size());
   endtask

   task automatic idle_inputs();
      en = 0; i = 0; cfg_we = 0; clr = 0;
   endtask

   task automatic do_reset();
      @(negedge ck);
      idle_inputs();
      rs = 0;
      model_reset();
      #1;
      chk_model("reset");
      @(negedge ck);
      rs = 1;
   endtask

   task automatic step(input string tag, input bit e, input bit b, input bit o,
                       input bit w, input logic [2:0] a, input logic [2:0] bb,
                       input bit c);
      @(negedge ck);
      en = e; i = b; ovl = o; cfg_we = w; cfg_a = a; cfg_b = bb; clr = c;
      @(posedge ck);
      model_edge(e, b, o, w, int'(a), int'(bb), c);
      #1;
      chk_model(tag);
      $display("txn %s en=%0b i=%0b ovl=%0b we=%0b clr=%0b -> y1=%0b y2=%0b cnt1=%0d cnt2=%0d fill=%0d",
               tag, e, b, o, w, c, y1, y2, cnt1, cnt2, fill);
   endtask

   typedef struct {
      bit en, i, ovl, we;
      logic [2:0] ca, cb;
      bit clr;
      bit ey1, ey2;
      int ec1, ec2, efill;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit e, bit b, bit o, bit w, logic [2:0] ca, logic [2:0] cb,
                              bit c, bit ey1, bit ey2, int ec1, int ec2, int ef);
      vec_t r;
      r.en = e; r.i = b; r.ovl = o; r.we = w; r.ca = ca; r.cb = cb; r.clr = c;
      r.ey1 = ey1; r.ey2 = ey2; r.ec1 = ec1; r.ec2 = ec2; r.efill = ef;
      return r;
   endfunction

   initial begin
      model_reset();
      // Basic A match, overlap and non-overlap runs, clr, pattern reload.
      tbl.push_back(v(1,0,1,0,0,0,0, 0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,0,0,0, 0,0,0,0,2));
      tbl.push_back(v(1,1,1,0,0,0,0, 1,0,1,0,3));
      tbl.push_back(v(0,0,1,0,0,0,0, 0,0,1,0,3));
      tbl.push_back(v(1,1,1,0,0,0,0, 0,0,1,0,3));
      tbl.push_back(v(1,1,1,0,0,0,0, 0,0,1,0,3));
      tbl.push_back(v(1,0,1,0,0,0,0, 0,1,1,1,3));
      tbl.push_back(v(1,0,1,0,0,0,0, 0,0,1,1,3));
      tbl.push_back(v(1,1,1,0,0,0,0, 1,0,2,1,3));
      tbl.push_back(v(1,1,0,0,0,0,0, 0,0,2,1,3));
      tbl.push_back(v(1,1,0,0,0,0,0, 0,0,2,1,3));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,1,2,2,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,0,2,2,1));
      tbl.push_back(v(1,1,0,0,0,0,0, 0,0,2,2,2));
      tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,2));
      tbl.push_back(v(1,1,1,1,3'b101,3'b101,0, 0,0,0,0,0));
      tbl.push_back(v(1,1,1,0,0,0,0, 0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,0,0,0, 0,0,0,0,2));
      tbl.push_back(v(1,1,1,0,0,0,0, 1,1,1,1,3));

      do_reset();
      foreach (tbl[k]) begin
         step($sformatf("vec%0d", k), tbl[k].en, tbl[k].i, tbl[k].ovl, tbl[k].we,
              tbl[k].ca, tbl[k].cb, tbl[k].clr);
         chk($sformatf("vec%0d.y1", k), int'(y1), int'(tbl[k].ey1));
         chk($sformatf("vec%0d.y2", k), int'(y2), int'(tbl[k].ey2));
         chk($sformatf("vec%0d.cnt1", k), int'(cnt1), tbl[k].ec1);
         chk($sformatf("vec%0d.cnt2", k), int'(cnt2), tbl[k].ec2);
         chk($sformatf("vec%0d.fill", k), int'(fill), tbl[k].efill);
      end

      // Counter saturation at CW=2, then clr colliding with a match.
      do_reset();
      for (int r = 0; r < 5; r++) begin
         step("sat0", 1, 0, 1, 0, 0, 0, 0);
         step("sat0", 1, 0, 1, 0, 0, 0, 0);
         step("sat1", 1, 1, 1, 0, 0, 0, 0);
      end
      chk("sat.cnt1_cw2", int'(cnt1s), 3);
      chk("sat.cnt1_cw8", int'(cnt1), 5);
      step("satc", 1, 0, 1, 0, 0, 0, 0);
      step("satc", 1, 0, 1, 0, 0, 0, 0);
      step("satc", 1, 1, 1, 0, 0, 0, 1);
      chk("clrprio.y1", int'(y1s), 1);
      chk("clrprio.cnt1_cw2", int'(cnt1s), 0);
      chk("clrprio.cnt1_cw8", int'(cnt1), 0);

      // en=0 gap must freeze history.
      do_reset();
      step("gap", 1, 0, 1, 0, 0, 0, 0);
      step("gap", 1, 0, 1, 0, 0, 0, 0);
      for (int g = 0; g < 3; g++) begin
         step("gapoff", 0, g[0], 1, 0, 0, 0, 0);
         chk("gap.fill", int'(fill), 2);
         chk("gap.y1", int'(y1), 0);
      end
      step("gap", 1, 1, 1, 0, 0, 0, 0);
      chk("gap.final_y1", int'(y1), 1);

      // Asynchronous reset mid-cycle discards partial history.
      do_reset();
      step("ar", 1, 0, 1, 0, 0, 0, 0);
      step("ar", 1, 0, 1, 0, 0, 0, 0);
      #2;
      rs = 0;
      #1;
      chk("async.fill", int'(fill), 0);
      chk("async.cnt1", int'(cnt1), 0);
      chk("async.y1", int'(y1), 0);
      model_reset();
      @(negedge ck);
      idle_inputs();
      rs = 1;
      step("ar", 1, 1, 1, 0, 0, 0, 0);
      chk("async.post_y1", int'(y1), 0);
      chk("async.post_fill", int'(fill), 1);

      // Randomized run against the model.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 40) == 0), 3'($urandom), 3'($urandom),
              ($urandom_range(0, 40) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
